// File: rtl/button_event_arbiter_pkg.sv
// Shared constants, slot-state encoding and the saturating add used by the
// button event arbiter and its round-robin picker.
package button_event_arbiter_pkg;

    localparam int          N_DEF   = 4;
    localparam int          DROP_W  = 8;
    localparam int unsigned CNT_MAX = (1 << DROP_W) - 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] base,
                                                  input int unsigned       inc);
        int unsigned sum;
        sum = 32'(base) + inc;
        if (sum > CNT_MAX) begin
            return DROP_W'(CNT_MAX);
        end
        return DROP_W'(sum);
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request found scanning
// upward from start_i, wrapping at N.
module rr_pick #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [CW-1:0] start_i,
    output logic          any_o,
    output logic [CW-1:0] idx_o
);

    int j;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j] && !mask_i[j]) begin
                any_o = 1'b1;
                idx_o = CW'(j);
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Sticky per-lane press requests delivered one at a time over valid/ready,
// with round-robin lane selection and a saturating dropped-press counter.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = $clog2(N)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [N-1:0]      Pulse,
    input  logic              Evt_Ready,
    input  logic              Clr,
    output logic              Evt_Valid,
    output logic [CW-1:0]     Evt_Code,
    output logic              Overflow,
    output logic [DROP_W-1:0] Drop_Cnt,
    output slot_state_e       Dbg_State,
    output logic [N-1:0]      Dbg_Pend
);

    // Handshake: an event transfers on a rising Clk edge where Evt_Valid and
    // Evt_Ready are both 1; Evt_Code is stable while Evt_Valid waits for Evt_Ready.

    slot_state_e       state_q, state_d;
    logic [N-1:0]      pend_q, pend_d;
    logic [CW-1:0]     code_q, code_d;
    logic [CW-1:0]     last_q, last_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]      grant_oh;
    logic [N-1:0]      mask;
    logic [N-1:0]      drop;
    logic [CW-1:0]     start;
    logic              pick_any;
    logic [CW-1:0]     pick_idx;
    int unsigned       drop_n;

    assign start = (last_q == CW'(N - 1)) ? '0 : last_q + CW'(1);

    // The lane sitting in the slot is not a candidate for its own replacement.
    always_comb begin
        mask = '0;
        if (state_q == ST_FULL) begin
            mask[code_q] = 1'b1;
        end
    end

    rr_pick #(.N(N), .CW(CW)) u_pick (
        .req_i   (pend_q),
        .mask_i  (mask),
        .start_i (start),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        last_d   = last_q;
        grant_oh = '0;
        case (state_q)
            ST_EMPTY: begin
                if (pick_any) begin
                    state_d            = ST_FULL;
                    code_d             = pick_idx;
                    last_d             = pick_idx;
                    grant_oh[pick_idx] = 1'b1;
                end
            end
            ST_FULL: begin
                if (Evt_Ready) begin
                    if (pick_any) begin
                        code_d             = pick_idx;
                        last_d             = pick_idx;
                        grant_oh[pick_idx] = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // A grant and a fresh press on the same lane re-arm the lane rather than drop.
    always_comb begin
        drop   = Pulse & pend_q & ~grant_oh;
        pend_d = (pend_q & ~grant_oh) | Pulse;
        drop_n = 0;
        for (int i = 0; i < N; i++) begin
            drop_n = drop_n + 32'(drop[i]);
        end
        ovf_d = (Clr ? 1'b0 : ovf_q) | (drop_n != 0);
        cnt_d = sat_add(Clr ? '0 : cnt_q, drop_n);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_EMPTY;
            pend_q  <= '0;
            code_q  <= '0;
            last_q  <= CW'(N - 1);
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Evt_Valid = (state_q == ST_FULL);
    assign Evt_Code  = code_q;
    assign Overflow  = ovf_q;
    assign Drop_Cnt  = cnt_q;
    assign Dbg_State = state_q;
    assign Dbg_Pend  = pend_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed-vector bench for button_event_arbiter with N=4; inputs are driven
// and outputs sampled 1ns after each rising edge.
module tb_button_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          Clk;
    logic          Rst;
    logic [N-1:0]  Pulse;
    logic          Evt_Ready;
    logic          Clr;
    logic          Evt_Valid;
    logic [CW-1:0] Evt_Code;
    logic          Overflow;
    logic [7:0]    Drop_Cnt;
    logic          Dbg_State;
    logic [N-1:0]  Dbg_Pend;

    int checks;
    int failures;

    button_event_arbiter #(.N(N), .CW(CW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Pulse     (Pulse),
        .Evt_Ready (Evt_Ready),
        .Clr       (Clr),
        .Evt_Valid (Evt_Valid),
        .Evt_Code  (Evt_Code),
        .Overflow  (Overflow),
        .Drop_Cnt  (Drop_Cnt),
        .Dbg_State (Dbg_State),
        .Dbg_Pend  (Dbg_Pend)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst       = 1'b0;
        Pulse     = '0;
        Evt_Ready = 1'b0;
        Clr       = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", Evt_Valid); end
        if (Evt_Code !== 2'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", Evt_Code); end
        if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", Overflow); end
        if (Drop_Cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", Drop_Cnt); end
        if (Dbg_Pend !== 4'b0000) begin failures++; $display("FAIL reset_pend got=%b exp=0000", Dbg_Pend); end
    endtask

    task automatic test_single();
        do_reset();
        Evt_Ready = 1'b1;
        Pulse = 4'b0100;
        tick();
        Pulse = '0;
        checks += 2;
        if (Dbg_Pend !== 4'b0100) begin failures++; $display("FAIL single_pend1 got=%b exp=0100", Dbg_Pend); end
        if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL single_valid1 got=%0b exp=0", Evt_Valid); end
        tick();
        checks += 3;
        if (Evt_Valid !== 1'b1) begin failures++; $display("FAIL single_valid2 got=%0b exp=1", Evt_Valid); end
        if (Evt_Code !== 2'd2) begin failures++; $display("FAIL single_code got=%0d exp=2", Evt_Code); end
        if (Dbg_Pend !== 4'b0000) begin failures++; $display("FAIL single_pend2 got=%b exp=0000", Dbg_Pend); end
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL single_valid3 got=%0b exp=0", Evt_Valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        Evt_Ready = 1'b1;
        Pulse = 4'b1111;
        tick();
        Pulse = '0;
        checks += 1;
        if (Dbg_Pend !== 4'b1111) begin failures++; $display("FAIL b2b_pend got=%b exp=1111", Dbg_Pend); end
        for (int i = 0; i < N; i++) begin
            tick();
            checks += 2;
            if (Evt_Valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, Evt_Valid); end
            if (Evt_Code !== CW'(i)) begin failures++; $display("FAIL b2b_code[%0d] got=%0d exp=%0d", i, Evt_Code, i); end
        end
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%0b exp=0", Evt_Valid); end
    endtask

    task automatic test_hold_drop();
        do_reset();
        Pulse = 4'b0010;
        tick();
        Pulse = '0;
        tick();
        checks += 2;
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd1) begin
            failures++; $display("FAIL hold_slot got=%0b/%0d exp=1/1", Evt_Valid, Evt_Code);
        end
        if (Dbg_Pend !== 4'b0000) begin failures++; $display("FAIL hold_pend0 got=%b exp=0000", Dbg_Pend); end
        Pulse = 4'b0010;
        tick();
        Pulse = '0;
        checks += 2;
        if (Dbg_Pend !== 4'b0010) begin failures++; $display("FAIL hold_pend1 got=%b exp=0010", Dbg_Pend); end
        if (Drop_Cnt !== 8'd0 || Overflow !== 1'b0) begin
            failures++; $display("FAIL hold_nodrop got=%0d/%0b exp=0/0", Drop_Cnt, Overflow);
        end
        Pulse = 4'b0010;
        tick();
        Pulse = '0;
        checks += 2;
        if (Drop_Cnt !== 8'd1 || Overflow !== 1'b1) begin
            failures++; $display("FAIL hold_drop got=%0d/%0b exp=1/1", Drop_Cnt, Overflow);
        end
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd1) begin
            failures++; $display("FAIL hold_stable got=%0b/%0d exp=1/1", Evt_Valid, Evt_Code);
        end
        Evt_Ready = 1'b1;
        tick();
        checks += 2;
        if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL hold_accept_valid got=%0b exp=0", Evt_Valid); end
        if (Dbg_Pend !== 4'b0010) begin failures++; $display("FAIL hold_accept_pend got=%b exp=0010", Dbg_Pend); end
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd1) begin
            failures++; $display("FAIL hold_again got=%0b/%0d exp=1/1", Evt_Valid, Evt_Code);
        end
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL hold_final got=%0b exp=0", Evt_Valid); end
    endtask

    task automatic test_multi_drop();
        do_reset();
        Pulse = 4'b0011;
        tick();
        Pulse = '0;
        tick();
        Pulse = 4'b0011;
        tick();
        checks += 1;
        if (Drop_Cnt !== 8'd1) begin failures++; $display("FAIL mdrop_one got=%0d exp=1", Drop_Cnt); end
        tick();
        Pulse = '0;
        checks += 1;
        if (Drop_Cnt !== 8'd3) begin failures++; $display("FAIL mdrop_two got=%0d exp=3", Drop_Cnt); end
    endtask

    task automatic test_no_starve();
        do_reset();
        Evt_Ready = 1'b1;
        Pulse = 4'b1001;
        tick();
        Pulse = 4'b0001;
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd0) begin
            failures++; $display("FAIL starve_first got=%0b/%0d exp=1/0", Evt_Valid, Evt_Code);
        end
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd3) begin
            failures++; $display("FAIL starve_lane3 got=%0b/%0d exp=1/3", Evt_Valid, Evt_Code);
        end
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd0) begin
            failures++; $display("FAIL starve_back0 got=%0b/%0d exp=1/0", Evt_Valid, Evt_Code);
        end
        Pulse = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        Pulse = 4'b0100;
        tick();
        Pulse = '0;
        tick();
        Pulse = 4'b0100;
        tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 9) begin
                checks += 1;
                if (Drop_Cnt !== 8'd10) begin failures++; $display("FAIL sat_mid got=%0d exp=10", Drop_Cnt); end
            end
        end
        checks += 2;
        if (Drop_Cnt !== 8'd255) begin failures++; $display("FAIL sat_max got=%0d exp=255", Drop_Cnt); end
        if (Overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", Overflow); end
        tick();
        checks += 1;
        if (Drop_Cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", Drop_Cnt); end
        Clr = 1'b1;
        tick();
        checks += 2;
        if (Drop_Cnt !== 8'd1) begin failures++; $display("FAIL clr_drop_cnt got=%0d exp=1", Drop_Cnt); end
        if (Overflow !== 1'b1) begin failures++; $display("FAIL clr_drop_ovf got=%0b exp=1", Overflow); end
        Pulse = '0;
        tick();
        Clr = 1'b0;
        checks += 1;
        if (Drop_Cnt !== 8'd0 || Overflow !== 1'b0) begin
            failures++; $display("FAIL clr_only got=%0d/%0b exp=0/0", Drop_Cnt, Overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        Pulse = 4'b0001;
        tick();
        Pulse = '0;
        tick();
        Pulse = 4'b1010;
        tick();
        Pulse = '0;
        checks += 1;
        if (Evt_Valid !== 1'b1 || Dbg_Pend !== 4'b1010) begin
            failures++; $display("FAIL rmid_setup got=%0b/%b exp=1/1010", Evt_Valid, Dbg_Pend);
        end
        Rst = 1'b0;
        #1;
        checks += 1;
        if ({Evt_Valid, Evt_Code, Overflow, Drop_Cnt, Dbg_Pend} !== '0) begin
            failures++; $display("FAIL rmid_async got=%0b/%0d/%0b/%0d/%b exp=all0",
                                 Evt_Valid, Evt_Code, Overflow, Drop_Cnt, Dbg_Pend);
        end
        #2;
        Rst = 1'b1;
        tick();
        Evt_Ready = 1'b1;
        Pulse = 4'b1000;
        tick();
        Pulse = '0;
        tick();
        checks += 1;
        if (Evt_Valid !== 1'b1 || Evt_Code !== 2'd3) begin
            failures++; $display("FAIL rmid_next got=%0b/%0d exp=1/3", Evt_Valid, Evt_Code);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 1;
            if (Evt_Valid !== 1'b0) begin failures++; $display("FAIL rmid_stale[%0d] got=%0b exp=0", i, Evt_Valid); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_drop();
        test_multi_drop();
        test_no_starve();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
